// File: rtl/mvm_sequencer.sv
// -----------------------------------------------------------------------------
// mvm_sequencer
//
// Control and datapath for the matrix-vector multiply accelerator behind the
// MVM, DIC and HS custom instructions. An accepted start fetches an N-vector x
// and then an NxN row-major matrix M through the shared data-memory port, and
// accumulates y = M*x into an internal result buffer. The sequencer gives way
// to the CPU in every cycle the CPU owns the port.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   acc_start     start request (ACC), accepted only in IDLE
//   mat_base      matrix base address, captured on an accepted start
//   vec_base      vector base address, captured on an accepted start
//   cpu_mem_busy  CPU owns the memory port this cycle; no request may issue
//   mem_req       read request to data memory
//   mem_addr      read address, valid while mem_req=1
//   mem_rdata     read data, valid one cycle after a granted request
//   dic_idx       result element select (DIC)
//   dic_data      y[dic_idx], combinational, live accumulator value
//   hs_ack        HS executed; releases DONE
//   hs_status     {zeros, done, busy}
//   busy          high while fetching (FETCH_X, FETCH_M)
//   done          high in DONE
// -----------------------------------------------------------------------------
module mvm_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_start,
    input  logic [ADDR_W-1:0] mat_base,
    input  logic [ADDR_W-1:0] vec_base,
    input  logic              cpu_mem_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [IDX_W-1:0]  dic_idx,
    output logic [DATA_W-1:0] dic_data,
    input  logic              hs_ack,
    output logic [DATA_W-1:0] hs_status,
    output logic              busy,
    output logic              done
);

    // Request counter must be able to hold N*N (one past the last matrix read).
    localparam int unsigned CNT_W  = 2 * IDX_W + 1;
    localparam int unsigned MIDX_W = 2 * IDX_W;

    localparam logic [CNT_W-1:0] X_REQS = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] M_REQS = CNT_W'(VEC_LEN * VEC_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH_X,
        S_FETCH_M,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mat_base_q, mat_base_d;
    logic [ADDR_W-1:0]   vec_base_q, vec_base_d;
    logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
    logic                pend_q, pend_d;
    logic                pend_m_q, pend_m_d;
    logic [MIDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic [DATA_W-1:0]   x_q [VEC_LEN];
    logic [DATA_W-1:0]   x_d [VEC_LEN];
    logic [DATA_W-1:0]   y_q [VEC_LEN];
    logic [DATA_W-1:0]   y_d [VEC_LEN];

    logic                reads_left;
    logic [IDX_W-1:0]    rsp_row;
    logic [IDX_W-1:0]    rsp_col;
    logic                last_m_rsp;
    logic [ADDR_W-1:0]   addr_base;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    always_comb begin
        reads_left = 1'b0;
        case (state_q)
            S_FETCH_X: reads_left = (req_cnt_q < X_REQS);
            S_FETCH_M: reads_left = (req_cnt_q < M_REQS);
            default:   reads_left = 1'b0;
        endcase
    end

    assign mem_req   = reads_left && !cpu_mem_busy;

    // Row-major layout makes i*N+j equal to the running request count, so one
    // counter serves both loops; the sum wraps naturally at ADDR_W bits.
    assign addr_base = (state_q == S_FETCH_M) ? mat_base_q : vec_base_q;
    assign mem_addr  = addr_base + ADDR_W'(req_cnt_q);

    // -------------------------------------------------------------------------
    // Response side: index of the word arriving this cycle
    // -------------------------------------------------------------------------
    assign rsp_row    = rsp_idx_q[MIDX_W-1:IDX_W];
    assign rsp_col    = rsp_idx_q[IDX_W-1:0];
    assign last_m_rsp = pend_q && pend_m_q && (rsp_idx_q == '1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mat_base_d = mat_base_q;
        vec_base_d = vec_base_q;
        req_cnt_d  = req_cnt_q;
        pend_d     = mem_req;
        pend_m_d   = (state_q == S_FETCH_M);
        rsp_idx_d  = req_cnt_q[MIDX_W-1:0];
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
        end

        if (mem_req) begin
            req_cnt_d = req_cnt_q + 1'b1;
        end

        // Responses are handled independently of the current state: the last
        // x word lands in the first FETCH_M cycle, tagged by pend_m_q=0.
        if (pend_q) begin
            if (pend_m_q) begin
                y_d[rsp_row] = y_q[rsp_row] + mem_rdata * x_q[rsp_col];
            end else begin
                x_d[rsp_col] = mem_rdata;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (acc_start) begin
                    mat_base_d = mat_base;
                    vec_base_d = vec_base;
                    req_cnt_d  = '0;
                    for (int unsigned i = 0; i < VEC_LEN; i++) begin
                        y_d[i] = '0;
                    end
                    state_d = S_FETCH_X;
                end
            end
            S_FETCH_X: begin
                if (mem_req && (req_cnt_q == X_LAST)) begin
                    req_cnt_d = '0;
                    state_d   = S_FETCH_M;
                end
            end
            S_FETCH_M: begin
                if (last_m_rsp) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (hs_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mat_base_q <= '0;
            vec_base_q <= '0;
            req_cnt_q  <= '0;
            pend_q     <= 1'b0;
            pend_m_q   <= 1'b0;
            rsp_idx_q  <= '0;
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mat_base_q <= mat_base_d;
            vec_base_q <= vec_base_d;
            req_cnt_q  <= req_cnt_d;
            pend_q     <= pend_d;
            pend_m_q   <= pend_m_d;
            rsp_idx_q  <= rsp_idx_d;
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU-visible outputs
    // -------------------------------------------------------------------------
    assign busy      = (state_q == S_FETCH_X) || (state_q == S_FETCH_M);
    assign done      = (state_q == S_DONE);
    assign hs_status = {{(DATA_W-2){1'b0}}, done, busy};
    assign dic_data  = y_q[dic_idx];

endmodule

// File: tb/tb_mvm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mvm_sequencer
//
// Self-checking bench for mvm_sequencer (N=4, 16-bit data and address).
// A behavioural memory answers granted reads one cycle later. Expected
// addresses and results are queued when a run is launched and consumed as the
// design issues requests and reaches DONE.
// -----------------------------------------------------------------------------
module tb_mvm_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acc_start = 1'b0;
    logic [15:0] mat_base = '0;
    logic [15:0] vec_base = '0;
    logic        cpu_mem_busy = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  dic_idx = '0;
    logic [15:0] dic_data;
    logic        hs_ack = 1'b0;
    logic [15:0] hs_status;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:65535];

    logic [15:0] addr_q [$];
    logic [15:0] res_q  [$];

    int n_checks = 0;
    int n_fail   = 0;

    mvm_sequencer #(
        .DATA_W (16),
        .ADDR_W (16),
        .VEC_LEN(N),
        .IDX_W  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_start   (acc_start),
        .mat_base    (mat_base),
        .vec_base    (vec_base),
        .cpu_mem_busy(cpu_mem_busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .dic_idx     (dic_idx),
        .dic_data    (dic_data),
        .hs_ack      (hs_ack),
        .hs_status   (hs_status),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Data memory: read data follows a granted request by one cycle; a
    // recognisable filler otherwise.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= mem[mem_addr];
        else         mem_rdata <= 16'hDEAD;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input logic [15:0] mb, input int i, input int j, input logic [15:0] v);
        mem[mb + 16'(i * N + j)] = v;
    endtask

    task automatic set_x(input logic [15:0] vb, input int j, input logic [15:0] v);
        mem[vb + 16'(j)] = v;
    endtask

    function automatic logic [15:0] model_y(input logic [15:0] mb, input logic [15:0] vb, input int i);
        logic [15:0] acc;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = acc + mem[mb + 16'(i * N + j)] * mem[vb + 16'(j)];
        end
        return acc;
    endfunction

    // Launch a run and follow it cycle by cycle until done (or reset cycle+1).
    task automatic run_op(input logic [15:0] mb, input logic [15:0] vb,
                          input int busy_from, input int busy_len,
                          input int pulse_cyc, input int rst_cyc,
                          input int exp_done);
        int c;
        bit seen;
        for (int j = 0; j < N; j++)     addr_q.push_back(vb + 16'(j));
        for (int k = 0; k < N * N; k++) addr_q.push_back(mb + 16'(k));
        for (int i = 0; i < N; i++)     res_q.push_back(model_y(mb, vb, i));

        @(posedge clk); #1;
        mat_base  = mb;
        vec_base  = vb;
        acc_start = 1'b1;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 200) begin
            @(posedge clk); #1;
            c++;
            acc_start    = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                mat_base = ~mb;
                vec_base = ~vb;
            end
            cpu_mem_busy = (c >= busy_from) && (c < busy_from + busy_len);
            rst_n        = (c != rst_cyc);
            #1;
            if (mem_req) begin
                if (addr_q.size() == 0) check_eq("extra_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                else                    check_eq("mem_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
            end
            if (cpu_mem_busy) check_eq("req_while_cpu", {31'h0, mem_req}, 32'h0);
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                check_eq("rst_busy", {31'h0, busy}, 32'h0);
                check_eq("rst_req", {31'h0, mem_req}, 32'h0);
                check_eq("rst_done", {31'h0, done}, 32'h0);
                for (int i = 0; i < N; i++) begin
                    dic_idx = 2'(i);
                    #1;
                    check_eq("rst_dic", {16'h0, dic_data}, 32'h0);
                end
                addr_q.delete();
                res_q.delete();
                return;
            end
            if (done) seen = 1'b1;
        end
        cpu_mem_busy = 1'b0;
        acc_start    = 1'b0;
        check_eq("done_cycle", c, exp_done);
        check_eq("addr_left", addr_q.size(), 0);
        check_eq("hs_done", {16'h0, hs_status}, 32'h2);
    endtask

    task automatic check_results();
        for (int i = 0; i < N; i++) begin
            dic_idx = 2'(i);
            #1;
            if (res_q.size() == 0) check_eq("res_missing", 32'h0, 32'h1);
            else                   check_eq("dic", {16'h0, dic_data}, {16'h0, res_q.pop_front()});
        end
    endtask

    task automatic read_dic(input int i, output logic [15:0] v);
        dic_idx = 2'(i);
        #1;
        v = dic_data;
    endtask

    task automatic ack_done();
        @(posedge clk); #1;
        hs_ack = 1'b1;
        @(posedge clk); #1;
        hs_ack = 1'b0;
        #1;
        check_eq("ack_status", {16'h0, hs_status}, 32'h0);
        check_eq("ack_done", {31'h0, done}, 32'h0);
    endtask

    initial begin
        logic [15:0] v;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req", {31'h0, mem_req}, 32'h0);
        check_eq("reset_busy", {31'h0, busy}, 32'h0);
        check_eq("reset_done", {31'h0, done}, 32'h0);
        check_eq("reset_status", {16'h0, hs_status}, 32'h0);
        for (int i = 0; i < N; i++) begin
            read_dic(i, v);
            check_eq("reset_dic", {16'h0, v}, 32'h0);
        end
        rst_n = 1'b1;

        // Identity matrix, x = 1..4
        for (int i = 0; i < N; i++) begin
            set_x(16'h0040, i, 16'(i + 1));
            for (int j = 0; j < N; j++) set_m(16'h0080, i, j, (i == j) ? 16'h1 : 16'h0);
        end
        run_op(16'h0080, 16'h0040, -1, 0, -1, -1, 22);
        check_results();
        for (int i = 0; i < N; i++) begin
            read_dic(i, v);
            check_eq("ident_y", {16'h0, v}, i + 1);
        end
        ack_done();

        // Contention: M all 2, CPU takes the port for 3 cycles mid FETCH_M
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) set_m(16'h0080, i, j, 16'h2);
        run_op(16'h0080, 16'h0040, 8, 3, -1, -1, 25);
        check_results();
        for (int i = 0; i < N; i++) begin
            read_dic(i, v);
            check_eq("cont_y", {16'h0, v}, 32'd20);
        end
        ack_done();

        // Overflow, plus an ignored start pulse in cycle 5
        for (int i = 0; i < N; i++) begin
            set_x(16'h0200, i, 16'h0);
            for (int j = 0; j < N; j++) set_m(16'h0100, i, j, 16'h0);
        end
        set_m(16'h0100, 0, 0, 16'h0100);
        set_x(16'h0200, 0, 16'h0100);
        set_m(16'h0100, 1, 1, 16'hFFFF);
        set_x(16'h0200, 1, 16'h0002);
        run_op(16'h0100, 16'h0200, -1, 0, 5, -1, 22);
        check_results();
        read_dic(0, v);
        check_eq("ovf_y0", {16'h0, v}, 32'h0000);
        read_dic(1, v);
        check_eq("ovf_y1", {16'h0, v}, 32'hFFFE);

        // Start pulse while in DONE is ignored
        @(posedge clk); #1;
        acc_start = 1'b1;
        mat_base  = 16'h3000;
        vec_base  = 16'h3100;
        @(posedge clk); #1;
        acc_start = 1'b0;
        #1;
        check_eq("done_hold", {31'h0, done}, 32'h1);
        check_eq("done_nobusy", {31'h0, busy}, 32'h0);
        check_eq("done_noreq", {31'h0, mem_req}, 32'h0);
        read_dic(1, v);
        check_eq("done_keep_y1", {16'h0, v}, 32'hFFFE);

        // Start together with ack: ack wins, no new run
        @(posedge clk); #1;
        acc_start = 1'b1;
        hs_ack    = 1'b1;
        @(posedge clk); #1;
        acc_start = 1'b0;
        hs_ack    = 1'b0;
        #1;
        check_eq("ackstart_done", {31'h0, done}, 32'h0);
        check_eq("ackstart_status", {16'h0, hs_status}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check_eq("ackstart_noreq", {31'h0, mem_req}, 32'h0);
            check_eq("ackstart_idle", {31'h0, busy}, 32'h0);
        end
        read_dic(1, v);
        check_eq("ack_keep_y1", {16'h0, v}, 32'hFFFE);

        // Reset in cycle 10, then a fresh run completes normally
        run_op(16'h0080, 16'h0040, -1, 0, -1, 10, 0);
        run_op(16'h0080, 16'h0040, -1, 0, -1, -1, 22);
        check_results();
        ack_done();

        // Matrix base near the top of the address space
        for (int i = 0; i < N; i++) begin
            set_x(16'h0040, i, 16'($urandom));
            for (int j = 0; j < N; j++) set_m(16'hFFF8, i, j, 16'($urandom));
        end
        run_op(16'hFFF8, 16'h0040, 3, 2, -1, -1, 24);
        check_results();
        ack_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
